// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Default 640x480@60 raster constants and the shared coordinate
//               type for the VGA timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int COORD_RANGE = 1024;

    typedef logic [9:0] coord_t;

    // Half-open window test [lo, hi) on unsigned 10-bit coordinates.
    function automatic logic in_window(input coord_t pos, input coord_t lo, input coord_t hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One raster axis: wrapping position counter plus sync/active
//               decode of the value the counter will hold after this edge.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = H_VISIBLE_DEF,
    parameter int FRONT   = H_FRONT_DEF,
    parameter int SYNC    = H_SYNC_DEF,
    parameter int BACK    = H_BACK_DEF
) (
    input  logic   vga_clk,
    input  logic   reset,
    input  logic   en,
    output coord_t pos,
    output coord_t next_pos,
    output logic   wrap,
    output logic   sync_n_next,
    output logic   active_next
);

    localparam int     TOTAL      = VISIBLE + FRONT + SYNC + BACK;
    localparam coord_t c_LAST     = coord_t'(TOTAL - 1);
    localparam coord_t c_VIS_END  = coord_t'(VISIBLE);
    localparam coord_t c_SYNC_LO  = coord_t'(VISIBLE + FRONT);
    localparam coord_t c_SYNC_HI  = coord_t'(VISIBLE + FRONT + SYNC);

    coord_t r_pos;
    coord_t w_next;
    logic   w_wrap;

    // Reset is folded into the next value so the decodes below already
    // describe the post-reset position.
    always_comb begin
        w_wrap = en && (r_pos == c_LAST);
        w_next = r_pos;
        if (reset) begin
            w_next = '0;
        end else if (w_wrap) begin
            w_next = '0;
        end else if (en) begin
            w_next = r_pos + coord_t'(1);
        end
    end

    always_ff @(posedge vga_clk) begin
        r_pos <= w_next;
    end

    assign pos         = r_pos;
    assign next_pos    = w_next;
    assign wrap        = w_wrap;
    assign sync_n_next = ~in_window(w_next, c_SYNC_LO, c_SYNC_HI);
    assign active_next = (w_next < c_VIS_END);

endmodule : vga_axis_counter
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : 640x480@60 raster timing: DrawX/DrawY, hs/vs, blank, strobes.
//               Optional macro VGA_FRAME_COUNT_EN adds a 16-bit frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic        vga_clk,
    input  logic        reset,
    output coord_t      DrawX,
    output coord_t      DrawY,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > COORD_RANGE) begin : g_h_total_check
            $error("vga_timing_gen: H_TOTAL %0d exceeds 10-bit range", H_TOTAL);
        end
        if (V_TOTAL > COORD_RANGE) begin : g_v_total_check
            $error("vga_timing_gen: V_TOTAL %0d exceeds 10-bit range", V_TOTAL);
        end
    endgenerate

    coord_t w_hc;
    coord_t w_vc;
    coord_t w_hc_next;
    coord_t w_vc_next;
    logic   w_h_wrap;
    logic   w_v_wrap_unused;
    logic   w_h_sync_n_next;
    logic   w_v_sync_n_next;
    logic   w_h_active_next;
    logic   w_v_active_next;
    logic   w_line_start_next;
    logic   w_frame_start_next;

    logic   r_hs;
    logic   r_vs;
    logic   r_blank;
    logic   r_line_start;
    logic   r_frame_start;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .en          (1'b1),
        .pos         (w_hc),
        .next_pos    (w_hc_next),
        .wrap        (w_h_wrap),
        .sync_n_next (w_h_sync_n_next),
        .active_next (w_h_active_next)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .en          (w_h_wrap),
        .pos         (w_vc),
        .next_pos    (w_vc_next),
        .wrap        (w_v_wrap_unused),
        .sync_n_next (w_v_sync_n_next),
        .active_next (w_v_active_next)
    );

    assign w_line_start_next  = (w_hc_next == '0);
    assign w_frame_start_next = w_line_start_next && (w_vc_next == '0);

    // Decodes come from next-state counters, so after the edge they line up
    // with DrawX/DrawY without any pipeline skew.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank       <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hs          <= w_h_sync_n_next;
            r_vs          <= w_v_sync_n_next;
            r_blank       <= w_h_active_next && w_v_active_next;
            r_line_start  <= w_line_start_next;
            r_frame_start <= w_frame_start_next;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_frame_count <= '0;
        end else if (w_frame_start_next) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

    assign DrawX       = w_hc;
    assign DrawY       = w_vc;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign blank       = r_blank;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule : vga_timing_gen
`default_nettype wire
